// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants for the UART-to-ALU command sequencer.
// State encoding, invalid-opcode marker and default error byte.
package alu_cmd_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t WAIT_A  = 3'd0;
    localparam state_t WAIT_B  = 3'd1;
    localparam state_t WAIT_OP = 3'd2;
    localparam state_t EXEC    = 3'd3;
    localparam state_t SEND    = 3'd4;
    localparam state_t WAIT_TX = 3'd5;

    localparam logic [7:0] OP_INVALID   = 8'hFF;
    localparam logic [7:0] ERR_CHAR_DEF = 8'h3F;

endpackage

// File: rtl/alu_cmd_sequencer_timeout.sv
// Inter-byte watchdog: ticks expire after TIMEOUT_CYCLES idle cycles.
// A clear in the expiry cycle suppresses the tick.
module frame_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expire = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || !enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Collects A, B, operator bytes from UART RX, drives the ALU,
// and returns the result (or an error byte) through UART TX.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int                DATA_W         = 8,
    parameter int                TIMEOUT_CYCLES = 50_000_000,
    parameter logic [DATA_W-1:0] ERR_CHAR       = DATA_W'(ERR_CHAR_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done_tick,
    input  logic [7:0]        opcode_in,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done_tick,
    output logic              err_tick,
    output logic              busy
);

    state_t state, state_nx;
    logic   expire;
    logic   op_bad;

    assign op_bad = (opcode_in == OP_INVALID);

    frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .enable(state == WAIT_B || state == WAIT_OP),
        .clear (rx_done_tick),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_A;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_A:  if (rx_done_tick) state_nx = WAIT_B;
            WAIT_B: begin
                if (rx_done_tick) state_nx = WAIT_OP;
                else if (expire)  state_nx = WAIT_A;
            end
            WAIT_OP: begin
                if (rx_done_tick) state_nx = op_bad ? SEND : EXEC;
                else if (expire)  state_nx = WAIT_A;
            end
            EXEC:    state_nx = SEND;
            SEND:    state_nx = WAIT_TX;
            WAIT_TX: if (tx_done_tick) state_nx = WAIT_A;
            default: state_nx = WAIT_A;
        endcase
    end

    always_comb begin
        tx_start = (state == SEND);
        busy     = (state != WAIT_A);
    end

    // Datapath registers; err_tick is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= 8'h00;
            tx_data  <= '0;
            err_tick <= 1'b0;
        end else begin
            err_tick <= 1'b0;
            unique case (state)
                WAIT_A: if (rx_done_tick) alu_a <= rx_data;
                WAIT_B: begin
                    if (rx_done_tick) alu_b    <= rx_data;
                    else if (expire)  err_tick <= 1'b1;
                end
                WAIT_OP: begin
                    if (rx_done_tick) begin
                        if (op_bad) begin
                            err_tick <= 1'b1;
                            tx_data  <= ERR_CHAR;
                        end else begin
                            alu_op <= opcode_in;
                        end
                    end else if (expire) begin
                        err_tick <= 1'b1;
                    end
                end
                EXEC:    tx_data <= alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed-frame bench with a scoreboard queue and a tx_start monitor.
// Models the ASCII converter, the ALU and a 10-cycle UART TX.
module tb_alu_cmd_sequencer;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic [7:0] opcode_in;
    logic [7:0] alu_a, alu_b, alu_op, alu_result, tx_data;
    logic       tx_start, tx_done_tick, err_tick, busy;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   err_seen = 0;

    alu_cmd_sequencer #(
        .DATA_W(8),
        .TIMEOUT_CYCLES(16),
        .ERR_CHAR(8'h3F)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_done_tick(rx_done_tick),
        .opcode_in(opcode_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result),
        .tx_data(tx_data), .tx_start(tx_start),
        .tx_done_tick(tx_done_tick),
        .err_tick(err_tick), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (rx_data)
            8'h2B:   opcode_in = 8'h20;
            8'h2D:   opcode_in = 8'h22;
            8'h58:   opcode_in = 8'h26;
            default: opcode_in = 8'hFF;
        endcase
    end

    always_comb begin
        case (alu_op)
            8'h20:   alu_result = alu_a + alu_b;
            8'h22:   alu_result = alu_a - alu_b;
            8'h26:   alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every tx_start must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && tx_start) begin
            if (q.size() == 0) begin
                chk("unexpected_tx_start", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tx_data", int'(tx_data), int'(e.tx));
                chk("alu_a", int'(alu_a), int'(e.a));
                chk("alu_b", int'(alu_b), int'(e.b));
                chk("alu_op", int'(alu_op), int'(e.op));
                chk("tx_latency_cycle", cyc, e.cyc);
            end
        end
        if (reset && err_tick) err_seen++;
    end

    // UART TX model: done pulse 10 cycles after the request.
    initial begin
        logic [7:0] held;
        tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && tx_start) begin
                held = tx_data;
                repeat (10) @(negedge clk);
                tx_done_tick = 1'b1;
                chk("tx_data_hold", int'(tx_data), int'(held));
                @(negedge clk);
                tx_done_tick = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || tx_done_tick) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(busy), 0);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] etx,
                         input logic [7:0] eop, input bit bad,
                         input bit inject);
        exp_t e;
        send_byte(a);
        send_byte(b);
        e.tx  = etx;
        e.a   = a;
        e.b   = b;
        e.op  = eop;
        e.cyc = cyc + (bad ? 1 : 2);
        q.push_back(e);
        send_byte(c);
        if (inject) begin
            repeat (3) @(negedge clk);
            chk("in_wait_tx", int'(busy), 1);
            send_byte(8'h55);
        end
        wait_idle("busy_after_done");
    endtask

    initial begin
        int t0;
        reset = 1'b0;
        rx_data = 8'h00;
        rx_done_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_flags", int'({tx_start, err_tick, busy}), 0);
        reset = 1'b1;
        @(negedge clk);

        frame(8'h05, 8'h03, 8'h2B, 8'h08, 8'h20, 1'b0, 1'b0);
        frame(8'h0C, 8'h0A, 8'h58, 8'h06, 8'h26, 1'b0, 1'b0);
        frame(8'h01, 8'h02, 8'h51, 8'h3F, 8'h26, 1'b1, 1'b0);
        chk("err_after_bad_op", err_seen, 1);

        t0 = cyc;
        send_byte(8'h07);
        while (cyc != t0 + 16) @(negedge clk);
        chk("timeout_not_early", int'({err_tick, busy}), 1);
        @(negedge clk);
        chk("timeout_err_tick", int'(err_tick), 1);
        chk("timeout_idle", int'(busy), 0);

        frame(8'h02, 8'h02, 8'h2B, 8'h04, 8'h20, 1'b0, 1'b1);
        frame(8'h09, 8'h01, 8'h2D, 8'h08, 8'h22, 1'b0, 1'b0);

        send_byte(8'h11);
        send_byte(8'h22);
        chk("in_wait_op", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_alu", int'({alu_a, alu_b, alu_op}), 0);
        chk("mid_rst_flags", int'({tx_data, tx_start, err_tick, busy}), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        frame(8'h2B, 8'h01, 8'h2B, 8'h2C, 8'h20, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("err_tick_total", err_seen, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
